// File: rtl/div_pkg.sv
// Shared CPU arithmetic-unit constants.
//   CPU_WIDTH      : default datapath width for the multi-cycle units
//   DIV_*          : divider FSM state encodings
//   MULT_*         : multiplier FSM state encodings and latency
// The divider and multiplier present identical busy/done handshakes, so the
// pipeline stall logic can treat either unit the same way.
package div_pkg;

   localparam int CPU_WIDTH = 32;

   // Divider FSM
   localparam logic [1:0] DIV_IDLE = 2'd0;
   localparam logic [1:0] DIV_RUN  = 2'd1;
   localparam logic [1:0] DIV_FIX  = 2'd2;

   // Multiplier FSM (kept here so both units share one encoding scheme)
   localparam logic [1:0] MULT_IDLE = 2'd0;
   localparam logic [1:0] MULT_RUN  = 2'd1;
   localparam logic [1:0] MULT_DONE = 2'd2;
   localparam int         MULT_CYCLES = 4;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration (purely combinational).
//   rem      : current partial remainder (WIDTH+1 bits)
//   dvd_bit  : next dividend bit, shifted in at the LSB
//   divisor  : divisor magnitude
//   rem_next : partial remainder after shift/compare/subtract
//   q_bit    : quotient bit produced by this iteration
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem,
   input  logic             dvd_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_next,
   output logic             q_bit
);

   // Two guard bits so the shifted remainder never overflows the compare.
   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] divisor_ext;

   assign shifted     = {rem, dvd_bit};
   assign divisor_ext = {2'b00, divisor};
   assign q_bit       = (shifted >= divisor_ext);
   assign rem_next    = q_bit ? (WIDTH+1)'(shifted - divisor_ext)
                              : (WIDTH+1)'(shifted);

endmodule

// File: rtl/div.sv
// Multi-cycle signed/unsigned integer divider (restoring, one bit per cycle).
//   clk   : clock, all state changes on rising edge
//   reset : synchronous active-high reset
//   start : request a divide (sampled only while idle)
//   sign  : 1 = signed, 0 = unsigned; captured with start
//   a, b  : dividend, divisor; captured with start
//   q, r  : registered quotient / remainder, held between done pulses
//   busy  : high while a divide is in progress
//   done  : one-cycle pulse when q/r/dz update
//   dz    : divide-by-zero flag, updated with q/r
module div
   import div_pkg::*;
#(
   parameter int WIDTH = CPU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             busy,
   output logic             done,
   output logic             dz
);

   localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

   logic [1:0]       state_reg;
   logic [5:0]       cnt_reg;
   logic [WIDTH:0]   rem_reg;
   logic [WIDTH-1:0] quo_reg;    // dividend bits shift out MSB, quotient bits shift in LSB
   logic [WIDTH-1:0] dvsr_reg;
   logic             q_neg_reg;
   logic             r_neg_reg;
   logic             dz_reg;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   rem_next;
   logic             q_bit;

   // Magnitudes; the most negative value maps onto itself, which is the
   // correct unsigned magnitude.
   assign a_mag = (sign && a[WIDTH-1]) ? -a : a;
   assign b_mag = (sign && b[WIDTH-1]) ? -b : b;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_reg),
      .dvd_bit  (quo_reg[WIDTH-1]),
      .divisor  (dvsr_reg),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= DIV_IDLE;
         cnt_reg   <= '0;
         rem_reg   <= '0;
         quo_reg   <= '0;
         dvsr_reg  <= '0;
         q_neg_reg <= 1'b0;
         r_neg_reg <= 1'b0;
         dz_reg    <= 1'b0;
         q         <= '0;
         r         <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         dz        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            DIV_IDLE: begin
               if (start) begin
                  quo_reg   <= a_mag;
                  dvsr_reg  <= b_mag;
                  rem_reg   <= '0;
                  q_neg_reg <= sign && (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_neg_reg <= sign && a[WIDTH-1];
                  dz_reg    <= (b == '0);
                  cnt_reg   <= '0;
                  busy      <= 1'b1;
                  state_reg <= DIV_RUN;
               end
            end
            DIV_RUN: begin
               rem_reg <= rem_next;
               quo_reg <= {quo_reg[WIDTH-2:0], q_bit};
               cnt_reg <= cnt_reg + 6'd1;
               if (cnt_reg == LAST_ITER)
                  state_reg <= DIV_FIX;
            end
            DIV_FIX: begin
               // With b==0 the iterations leave rem = |a| and every quotient
               // bit set, so only q needs forcing; the remainder sign fix
               // restores the original a.
               if (dz_reg)
                  q <= '1;
               else
                  q <= q_neg_reg ? -quo_reg : quo_reg;
               r         <= r_neg_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
               dz        <= dz_reg;
               done      <= 1'b1;
               busy      <= 1'b0;
               state_reg <= DIV_IDLE;
            end
            default: state_reg <= DIV_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div.sv
// Self-checking testbench for div: directed corner cases plus randomized
// divides compared against an arithmetic reference model.
module tb_div;

   logic        clk;
   logic        reset;
   logic        start;
   logic        sign;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] q;
   logic [31:0] r;
   logic        busy;
   logic        done;
   logic        dz;

   int tests_run = 0;
   int tests_failed = 0;

   logic [31:0] held_q = '0;
   logic [31:0] held_r = '0;

   div #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .sign  (sign),
      .a     (a),
      .b     (b),
      .q     (q),
      .r     (r),
      .busy  (busy),
      .done  (done),
      .dz    (dz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: SV arithmetic truncates toward zero, remainder takes the
   // dividend's sign; divide-by-zero and signed overflow handled explicitly.
   task automatic model(input logic s, input logic [31:0] aa, input logic [31:0] bb,
                        output logic [31:0] eq, output logic [31:0] er, output logic ez);
      ez = (bb == 0);
      if (bb == 0) begin
         eq = 32'hFFFF_FFFF;
         er = aa;
      end else if (s && aa == 32'h8000_0000 && bb == 32'hFFFF_FFFF) begin
         eq = 32'h8000_0000;
         er = 32'h0;
      end else if (s) begin
         eq = 32'($signed(aa) / $signed(bb));
         er = 32'($signed(aa) % $signed(bb));
      end else begin
         eq = aa / bb;
         er = aa % bb;
      end
   endtask

   // Waits for done counting rising edges, the start-sampling edge being #1.
   // Called at the negedge following the start edge; returns at the negedge
   // where done is first seen high (or when the budget runs out).
   task automatic wait_done(output int edges);
      edges = 1;
      while (!done && edges < 60) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
   endtask

   // One complete divide. If poke is set, start is re-pulsed with different
   // operands mid-RUN; it must be ignored.
   task automatic run_div(input string tag, input logic s, input logic [31:0] aa,
                          input logic [31:0] bb, input bit poke);
      logic [31:0] eq, er;
      logic ez;
      int edges;
      model(s, aa, bb, eq, er, ez);
      @(negedge clk);
      start = 1'b1; sign = s; a = aa; b = bb;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; sign = ~s; a = $urandom; b = $urandom;
      check({tag, " busy"}, {31'b0, busy}, 32'd1);
      check({tag, " q held"}, q, held_q);
      if (poke) begin
         repeat (5) @(negedge clk);
         start = 1'b1; a = $urandom; b = $urandom;
         @(negedge clk);
         start = 1'b0;
         check({tag, " r held mid-run"}, r, held_r);
      end
      wait_done(edges);
      check({tag, " latency"}, edges, poke ? 34 - 6 : 34);
      check({tag, " q"}, q, eq);
      check({tag, " r"}, r, er);
      check({tag, " dz"}, {31'b0, dz}, {31'b0, ez});
      check({tag, " busy at done"}, {31'b0, busy}, 32'd0);
      $display("[TB] %s sign=%0d a=%h b=%h -> q=%h r=%h dz=%0d", tag, s, aa, bb, q, r, dz);
      held_q = eq;
      held_r = er;
   endtask

   initial begin
      int edges;
      int done_seen;
      logic [31:0] eq1, er1, eq2, er2;
      logic ez1, ez2;

      reset = 1'b1; start = 1'b0; sign = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset q", q, 32'h0);
      check("reset r", r, 32'h0);
      check("reset busy/done/dz", {29'b0, busy, done, dz}, 32'h0);
      reset = 1'b0;

      // Directed cases
      run_div("u100/7",      1'b0, 32'd100,         32'd7,           1'b0);
      run_div("s-7/2",       1'b1, 32'hFFFF_FFF9,   32'd2,           1'b0);
      run_div("s7/-2",       1'b1, 32'd7,           32'hFFFF_FFFE,   1'b0);
      run_div("s dz",        1'b1, 32'h1234_5678,   32'h0,           1'b0);
      run_div("u dz",        1'b0, 32'h1234_5678,   32'h0,           1'b0);
      run_div("s ovf",       1'b1, 32'h8000_0000,   32'hFFFF_FFFF,   1'b0);
      run_div("uFFFF/1",     1'b0, 32'hFFFF_FFFF,   32'd1,           1'b0);
      run_div("poke",        1'b0, 32'd1000,        32'd33,          1'b1);

      // Reset 10 cycles into RUN: aborted, no done
      @(negedge clk);
      start = 1'b1; sign = 1'b0; a = 32'd999; b = 32'd5;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort busy", {31'b0, busy}, 32'd0);
      check("abort q", q, 32'h0);
      check("abort r", r, 32'h0);
      done_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("abort no done", done_seen, 0);
      $display("[TB] abort reset mid-run -> busy=%0d q=%h r=%h dones=%0d", busy, q, r, done_seen);
      held_q = '0;
      held_r = '0;

      // Start held high across done: back-to-back divides
      model(1'b0, 32'd500, 32'd9, eq1, er1, ez1);
      model(1'b1, 32'hFFFF_FC18, 32'd7, eq2, er2, ez2);
      @(negedge clk);
      start = 1'b1; sign = 1'b0; a = 32'd500; b = 32'd9;
      @(posedge clk);
      @(negedge clk);
      sign = 1'b1; a = 32'hFFFF_FC18; b = 32'd7;   // ignored until done
      wait_done(edges);
      check("b2b first latency", edges, 34);
      check("b2b first q", q, eq1);
      check("b2b first r", r, er1);
      $display("[TB] b2b first a=%h b=%h -> q=%h r=%h", 32'd500, 32'd9, q, r);
      @(posedge clk);                                  // samples start in done cycle
      @(negedge clk);
      start = 1'b0;
      check("b2b second busy", {31'b0, busy}, 32'd1);
      check("b2b q held", q, eq1);
      wait_done(edges);
      check("b2b second latency", edges, 34);
      check("b2b second q", q, eq2);
      check("b2b second r", r, er2);
      check("b2b second dz", {31'b0, dz}, {31'b0, ez2});
      $display("[TB] b2b second a=%h b=%h -> q=%h r=%h", 32'hFFFF_FC18, 32'd7, q, r);
      held_q = eq2;
      held_r = er2;

      // Randomized divides
      for (int i = 0; i < 24; i++) begin
         logic        rs;
         logic [31:0] ra, rb;
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         case ($urandom_range(0, 5))
            0:       rb = 32'h0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
            3:       rb = $urandom >> $urandom_range(0, 31);
            default: rb = $urandom;
         endcase
         run_div("rand", rs, ra, rb, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; all requirements below use WIDTH=32.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a divide; sampled only while busy=0.
REQ-005 SHALL have port sign  input  1  1=signed (DIV), 0=unsigned (DIVU); captured with start.
REQ-006 SHALL have port a  input  WIDTH  dividend; captured with start.
REQ-007 SHALL have port b  input  WIDTH  divisor; captured with start.
REQ-008 SHALL have port q  output  WIDTH  quotient, registered.
REQ-009 SHALL have port r  output  WIDTH  remainder, registered.
REQ-010 SHALL have port busy  output  1  high while a divide is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when q/r update.
REQ-012 SHALL have port dz  output  1  divide-by-zero flag, updated with q/r.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIX; IDLE->RUN on start=1; RUN->FIX after 32 iterations; FIX->IDLE unconditionally.
REQ-014 SHALL, on the edge sampling start=1 in IDLE: latch sign, operand magnitudes (abs value if sign=1), result-sign bits, b==0 flag; clear 6-bit iteration counter; set busy=1.
REQ-015 SHALL perform one restoring shift-subtract iteration per RUN cycle over a 33-bit partial remainder, one quotient bit per cycle, MSB first.
REQ-016 SHALL, in FIX, negate quotient if dividend and divisor signs differ and negate remainder if dividend negative (signed only), register q/r/dz, pulse done=1, clear busy.
REQ-017 SHALL assert done exactly 34 cycles after the start-sampling edge (1 capture + 32 RUN + 1 FIX); busy high for 33 cycles ending at the edge done rises.
REQ-018 SHALL truncate quotient toward zero; remainder sign equals dividend sign; a = q*b + r holds for all b!=0.
REQ-019 SHALL, for b==0, produce q=32'hFFFFFFFF, r=a (original value), dz=1, same latency; otherwise dz=0.
REQ-020 SHALL, for signed 32'h80000000 / 32'hFFFFFFFF, produce q=32'h80000000, r=0, dz=0 (wrap, no trap).
REQ-021 SHALL ignore start while busy=1 (no restart, no captured operands changed).
REQ-022 SHALL accept start in the cycle done is high (state IDLE), giving back-to-back divides.
REQ-023 SHALL hold q, r, dz unchanged between done pulses, including throughout a new operation.

Reset
REQ-024 SHALL, when reset=1 at an edge, enter IDLE and set q=0, r=0, busy=0, done=0, dz=0, counter=0.
REQ-025 SHALL give reset priority over start and over any in-progress iteration; an aborted divide produces no done.

Structure
REQ-026 SHALL take FSM state encodings and WIDTH default from the shared CPU constants package, alongside the multiplier's definitions.
REQ-027 SHALL place the single-iteration compare/subtract/shift in a combinational sub-module div_step; div holds FSM, counter, registers.
REQ-028 SHALL expose the same busy semantics the pipeline stall logic already uses for mult.

Verification
REQ-029 SHALL cover: unsigned 100/7 -> q=14, r=2, dz=0, done exactly 34 cycles after start edge.
REQ-030 SHALL cover: signed -7/2 -> q=32'hFFFFFFFD, r=32'hFFFFFFFF; signed 7/-2 -> q=32'hFFFFFFFD, r=1.
REQ-031 SHALL cover: a=32'h12345678, b=0, either sign -> q=32'hFFFFFFFF, r=32'h12345678, dz=1.
REQ-032 SHALL cover: signed 32'h80000000/32'hFFFFFFFF -> q=32'h80000000, r=0; unsigned 32'hFFFFFFFF/1 -> q=32'hFFFFFFFF, r=0.
REQ-033 SHALL cover: reset asserted 10 cycles into RUN -> busy=0 and q=r=0 next cycle, no done; start pulsed mid-RUN -> ignored, original result delivered.
REQ-034 SHALL cover: start held high across done -> second divide begins in the done cycle, second done 34 cycles later.
